// File: rtl/layer_out_serializer_pkg.sv
// Shared types and helpers for the layer output serializer.
//   state_t     : serializer FSM states (IDLE, STREAM)
//   clog2_min1  : index width helper, never returns less than 1
//   NN_WORD_T   : signed neuron word type of a given width
`ifndef NN_WORD_T
`define NN_WORD_T(w) logic signed [(w)-1:0]
`endif

package layer_out_serializer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Largest supported neuron count; index widths are derived from NN.
  localparam int NN_MAX = 1024;

  // Width of an index able to address n words; a single word still gets
  // one bit so ports never collapse to zero width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_out_serializer_if.sv
// Bundle of all non-clock signals of the layer output serializer.
//   in_valid/in_data/in_ready   : parallel vector capture from the neuron array
//   out_valid/out_data/out_index/out_last/out_ready : serial word stream
//   max_valid/max_index/max_value : argmax result of the last vector
//   overrun/sync_err              : sticky error flags
//   dbg_state                     : current FSM state, for observation only
// Handshake rule for both sides: a word or vector moves on a cycle where its
// valid and the matching ready are both high; the producer keeps valid and
// payload stable until that happens.
// Modports: slave = the serializer itself, master = the environment around it.
interface layer_out_serializer_if #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
);
  import layer_out_serializer_pkg::*;

  localparam int IW = clog2_min1(NN);

  logic [NN-1:0]           in_valid;
  logic [NN*dataWidth-1:0] in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic [dataWidth-1:0]    out_data;
  logic [IW-1:0]           out_index;
  logic                    out_last;
  logic                    out_ready;
  logic                    max_valid;
  logic [IW-1:0]           max_index;
  logic [dataWidth-1:0]    max_value;
  logic                    overrun;
  logic                    sync_err;
  state_t                  dbg_state;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last,
           max_valid, max_index, max_value, overrun, sync_err, dbg_state
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last,
           max_valid, max_index, max_value, overrun, sync_err, dbg_state
  );

endinterface

// File: rtl/layer_out_serializer_argmax_tracker.sv
// Running signed argmax over the serial word stream.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   word       : word being transferred (signed two's complement)
//   index      : index of that word within its vector
//   xfer       : a word is transferred this cycle
//   first/last : the transferred word is index 0 / index NN-1
//   max_valid  : one-cycle pulse, the cycle after the last transfer
//   max_index  : index of the largest word (held)
//   max_value  : value of the largest word (held)
module layer_out_serializer_argmax_tracker
  import layer_out_serializer_pkg::*;
#(
  parameter int  dataWidth = 16,
  parameter int  NN        = 30,
  localparam int IW        = clog2_min1(NN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] word,
  input  logic [IW-1:0]        index,
  input  logic                 xfer,
  input  logic                 first,
  input  logic                 last,
  output logic                 max_valid,
  output logic [IW-1:0]        max_index,
  output logic [dataWidth-1:0] max_value
);

  `NN_WORD_T(dataWidth) run_max;
  `NN_WORD_T(dataWidth) cand_val;
  logic [IW-1:0]        run_idx;
  logic [IW-1:0]        cand_idx;

  // Word 0 always seeds the running maximum. Later words win only when
  // strictly greater, so ties keep the lowest index.
  always_comb begin
    cand_val = run_max;
    cand_idx = run_idx;
    if (first || ($signed(word) > run_max)) begin
      cand_val = $signed(word);
      cand_idx = index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max   <= '0;
      run_idx   <= '0;
      max_valid <= 1'b0;
      max_index <= '0;
      max_value <= '0;
    end else begin
      max_valid <= xfer && last;
      if (xfer) begin
        run_max <= cand_val;
        run_idx <= cand_idx;
        if (last) begin
          max_value <= cand_val;
          max_index <= cand_idx;
        end
      end
    end
  end

endmodule

// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs once every neuron reports
// valid and replays them as a serial stream, one word per handshake, to the
// next layer. Optionally tracks the signed argmax of each vector.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : layer_out_serializer_if.slave (capture side, stream side, argmax
//          result, sticky error flags, FSM state)
// Parameters: NN neurons, dataWidth bits per word, ARGMAX_EN enables tracker.
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int NN        = 30,
  parameter int dataWidth = 16,
  parameter bit ARGMAX_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  layer_out_serializer_if.slave  bus
);

  localparam int            IW   = clog2_min1(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  state_t               state;
  state_t               state_nxt;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_nxt;
  logic [dataWidth-1:0] buf_q [NN];

  logic out_valid;
  logic at_last;
  logic xfer;
  logic in_ready;
  logic full;
  logic partial;
  logic cap;

  assign out_valid = (state == STREAM);
  assign at_last   = (idx == LAST);
  assign xfer      = out_valid && bus.out_ready;
  // Ready also during the final transfer so a new vector can be taken in the
  // same cycle without a bubble; this makes in_ready combinational on
  // out_ready.
  assign in_ready  = (state == IDLE) || (xfer && at_last);
  assign full      = &bus.in_valid;
  assign partial   = (|bus.in_valid) && !full;
  assign cap       = full && in_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (cap) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (at_last) begin
            idx_nxt   = '0;
            state_nxt = cap ? STREAM : IDLE;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      bus.overrun  <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (full && !in_ready) begin
        bus.overrun <= 1'b1;
      end
      if (partial) begin
        bus.sync_err <= 1'b1;
      end
    end
  end

  // Vector storage needs no reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < NN; i++) begin
        buf_q[i] <= bus.in_data[i*dataWidth +: dataWidth];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = buf_q[idx];
  assign bus.out_index = idx;
  assign bus.out_last  = out_valid && at_last;
  assign bus.dbg_state = state;

  generate
    if (ARGMAX_EN) begin : g_argmax
      layer_out_serializer_argmax_tracker #(
        .dataWidth (dataWidth),
        .NN        (NN)
      ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .word      (buf_q[idx]),
        .index     (idx),
        .xfer      (xfer),
        .first     (idx == '0),
        .last      (at_last),
        .max_valid (bus.max_valid),
        .max_index (bus.max_index),
        .max_value (bus.max_value)
      );
    end else begin : g_no_argmax
      assign bus.max_valid = 1'b0;
      assign bus.max_index = '0;
      assign bus.max_value = '0;
    end
  endgenerate

endmodule

// File: tb/tb_layer_out_serializer.sv
module tb_layer_out_serializer;
  import layer_out_serializer_pkg::*;

  localparam int NA  = 4;
  localparam int W   = 16;
  localparam int IWA = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_out_serializer_if #(.NN(NA), .dataWidth(W)) ia ();
  layer_out_serializer_if #(.NN(1),  .dataWidth(W)) ib ();

  layer_out_serializer #(.NN(NA), .dataWidth(W), .ARGMAX_EN(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  layer_out_serializer #(.NN(1), .dataWidth(W), .ARGMAX_EN(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model (DUT A) ----------------
  // The stream is a queue of pending words; the head is what must be shown.
  logic [W-1:0]   exp_q[$];
  logic [IWA-1:0] vmax_idx_q[$];
  logic [W-1:0]   vmax_val_q[$];
  logic           m_overrun = 1'b0;
  logic           m_sync    = 1'b0;
  logic           m_pulse   = 1'b0;
  logic [IWA-1:0] m_max_idx = '0;
  logic [W-1:0]   m_max_val = '0;

  always @(posedge clk) begin : model
    logic ready;
    logic full;
    int   bi;
    logic signed [W-1:0] bv;
    if (rst) begin
      exp_q.delete();
      vmax_idx_q.delete();
      vmax_val_q.delete();
      m_overrun = 1'b0;
      m_sync    = 1'b0;
      m_pulse   = 1'b0;
      m_max_idx = '0;
      m_max_val = '0;
    end else begin
      full    = &ia.in_valid;
      ready   = (exp_q.size() == 0) || (exp_q.size() == 1 && ia.out_ready);
      m_pulse = 1'b0;
      if (exp_q.size() > 0 && ia.out_ready) begin
        if (exp_q.size() == 1) begin
          m_max_idx = vmax_idx_q.pop_front();
          m_max_val = vmax_val_q.pop_front();
          m_pulse   = 1'b1;
        end
        void'(exp_q.pop_front());
      end
      if (full && ready) begin
        bi = 0;
        bv = $signed(ia.in_data[W-1:0]);
        for (int i = 0; i < NA; i++) begin
          exp_q.push_back(ia.in_data[i*W +: W]);
          if ($signed(ia.in_data[i*W +: W]) > bv) begin
            bv = $signed(ia.in_data[i*W +: W]);
            bi = i;
          end
        end
        vmax_idx_q.push_back(IWA'(bi));
        vmax_val_q.push_back(bv);
      end
      if (full && !ready) m_overrun = 1'b1;
      if ((|ia.in_valid) && !full) m_sync = 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    int sz;
    sz = exp_q.size();
    check("out_valid", ia.out_valid, sz > 0);
    check("dbg_state", ia.dbg_state, (sz > 0) ? STREAM : IDLE);
    if (sz > 0) begin
      check("out_data",  $signed(ia.out_data), $signed(exp_q[0]));
      check("out_index", ia.out_index, NA - sz);
      check("out_last",  ia.out_last, sz == 1);
    end else begin
      check("out_last_idle", ia.out_last, 0);
    end
    check("in_ready",  ia.in_ready, (sz == 0) || (sz == 1 && ia.out_ready));
    check("max_valid", ia.max_valid, m_pulse);
    check("max_index", ia.max_index, m_max_idx);
    check("max_value", $signed(ia.max_value), $signed(m_max_val));
    check("overrun",   ia.overrun, m_overrun);
    check("sync_err",  ia.sync_err, m_sync);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NA*W-1:0] pack4(input int a, input int b,
                                            input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic step(input logic [NA-1:0] v, input logic [NA*W-1:0] d,
                      input logic rdy, input logic r);
    ia.in_valid  = v;
    ia.in_data   = d;
    ia.out_ready = rdy;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b1, 1'b0);
  endtask

  localparam logic [NA-1:0] FULL = '1;

  // ---------------- stimulus ----------------
  initial begin
    logic [NA*W-1:0] d;
    logic [NA-1:0]   v;
    logic [W-1:0]    bval;
    int              r;

    ib.in_valid  = 1'b0;
    ib.in_data   = '0;
    ib.out_ready = 1'b1;
    step('0, '0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1);

    check("rst_out_valid", ia.out_valid, 0);
    check("rst_out_last",  ia.out_last, 0);
    check("rst_max_valid", ia.max_valid, 0);
    check("rst_max_index", ia.max_index, 0);
    check("rst_max_value", ia.max_value, 0);
    check("rst_overrun",   ia.overrun, 0);
    check("rst_sync_err",  ia.sync_err, 0);
    check("rst_in_ready",  ia.in_ready, 1);

    // Basic stream {3,-2,7,7}
    step(FULL, pack4(3, -2, 7, 7), 1'b1, 1'b0);
    check("basic_w0", $signed(ia.out_data), 3);
    idle(3);
    check("basic_last", ia.out_last, 1);
    check("basic_w3", $signed(ia.out_data), 7);
    idle(1);
    check("basic_max_valid", ia.max_valid, 1);
    check("basic_max_index", ia.max_index, 2);
    check("basic_max_value", $signed(ia.max_value), 7);
    idle(1);
    check("basic_pulse_end", ia.max_valid, 0);

    // Backpressure on words 1..
    step(FULL, pack4(3, -2, 7, 7), 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("bp_hold_data",  $signed(ia.out_data), -2);
    check("bp_hold_index", ia.out_index, 1);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("bp_hold_data2", $signed(ia.out_data), -2);
    idle(3);
    check("bp_max_valid", ia.max_valid, 1);
    check("bp_max_index", ia.max_index, 2);
    idle(1);

    // Back-to-back vectors
    step(FULL, pack4(3, -2, 7, 7), 1'b1, 1'b0);
    idle(3);
    check("b2b_in_ready", ia.in_ready, 1);
    step(FULL, pack4(1, 1, 1, 9), 1'b1, 1'b0);
    check("b2b_valid", ia.out_valid, 1);
    check("b2b_w0", $signed(ia.out_data), 1);
    check("b2b_idx0", ia.out_index, 0);
    check("b2b_first_max", $signed(ia.max_value), 7);
    idle(4);
    check("b2b_max_valid", ia.max_valid, 1);
    check("b2b_max_index", ia.max_index, 3);
    check("b2b_max_value", $signed(ia.max_value), 9);
    idle(1);

    // Overrun mid-stream
    step(FULL, pack4(3, -2, 7, 7), 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step(FULL, pack4(5, 5, 5, 5), 1'b1, 1'b0);
    check("ovr_flag", ia.overrun, 1);
    check("ovr_w2", $signed(ia.out_data), 7);
    check("ovr_idx", ia.out_index, 2);
    idle(3);
    check("ovr_done", ia.out_valid, 0);
    check("ovr_max_value", $signed(ia.max_value), 7);

    // Partial valid
    step(4'b0101, pack4(1, 2, 3, 4), 1'b1, 1'b0);
    check("sync_flag", ia.sync_err, 1);
    check("sync_no_cap", ia.out_valid, 0);
    idle(1);
    check("sync_no_cap2", ia.out_valid, 0);

    // Reset at word 2
    step(FULL, pack4(3, -2, 7, 7), 1'b1, 1'b0);
    idle(2);
    check("rstm_at_w2", ia.out_index, 2);
    step('0, '0, 1'b1, 1'b1);
    check("rstm_out_valid", ia.out_valid, 0);
    check("rstm_overrun", ia.overrun, 0);
    check("rstm_sync_err", ia.sync_err, 0);
    idle(1);
    check("rstm_no_max", ia.max_valid, 0);
    idle(1);

    // All-negative vector
    step(FULL, pack4(-8, -3, -9, -3), 1'b1, 1'b0);
    idle(4);
    check("neg_max_index", ia.max_index, 1);
    check("neg_max_value", $signed(ia.max_value), -3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      v = FULL;
      else if (r < 58) v = NA'($urandom_range(1, 14));
      else             v = '0;
      for (int i = 0; i < NA; i++) begin
        d[i*W +: W] = W'($urandom_range(0, 15)) - W'(8);
      end
      step(v, d, $urandom_range(0, 3) != 0,
           (n == 200) || ($urandom_range(0, 199) == 0));
    end
    idle(6);

    // NN=1 instance
    ib.in_valid = 1'b1;
    ib.in_data  = W'(-5);
    idle(1);
    check("nn1_valid", ib.out_valid, 1);
    check("nn1_data", $signed(ib.out_data), -5);
    check("nn1_last", ib.out_last, 1);
    check("nn1_index", ib.out_index, 0);
    ib.in_valid = 1'b0;
    idle(1);
    check("nn1_max_valid", ib.max_valid, 1);
    check("nn1_max_index", ib.max_index, 0);
    check("nn1_max_value", $signed(ib.max_value), -5);
    for (int k = 0; k < 4; k++) begin
      bval        = W'($urandom_range(0, 65535));
      ib.in_valid = 1'b1;
      ib.in_data  = bval;
      idle(1);
      check("nn1_rand_data", $signed(ib.out_data), $signed(bval));
      check("nn1_rand_last", ib.out_last, 1);
      ib.in_valid = 1'b0;
      idle(1);
      check("nn1_rand_max", $signed(ib.max_value), $signed(bval));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
